// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory link arbiter.
// Timer width and error data default are used only when MEM_ARB_TIMEOUT_EN is defined.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    localparam logic        REQ_CPU       = 1'b0;
    localparam logic        REQ_DBG       = 1'b1;
    localparam logic [31:0] ERR_RDATA_DEF = 32'hFFFF_FFFF;
    localparam int          TMR_W         = 20;

    // Round-robin pick: on contention the requester that did not own the last grant wins.
    function automatic logic pick_winner(input logic act0, input logic act1,
                                         input logic last_gnt);
        if (act0 && act1) return ~last_gnt;
        else if (act0)    return REQ_CPU;
        else              return REQ_DBG;
    endfunction

endpackage

// File: rtl/mem_arb_timeout.sv
// WAIT-phase watchdog: clear/enable counter that flags expiry at LIMIT-1.
// Instantiated by mem_port_arbiter only when MEM_ARB_TIMEOUT_EN is defined.
module mem_arb_timeout
    import mem_arb_pkg::*;
#(
    parameter int LIMIT = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam logic [TMR_W-1:0] LAST = TMR_W'(LIMIT - 1);

    logic [TMR_W-1:0] r_cnt;

    assign o_expired = (r_cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_en && !o_expired)
            r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter/sequencer multiplexing two requesters onto one serial memory link.
// Define MEM_ARB_TIMEOUT_EN to abort transactions the link never completes (err pulse).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 4096,
    parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr0,
    input  logic        rd0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    output logic [31:0] rdata0,
    output logic        done0,
    input  logic        wr1,
    input  logic        rd1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    output logic [31:0] rdata1,
    output logic        done1,
    output logic        err,
    output logic        write_enable,
    output logic        read_enable,
    output logic [31:0] address,
    output logic [31:0] write_data,
    input  logic [31:0] read_data,
    input  logic        mem_done,
    output logic        busy
);

    arb_state_t r_state;
    logic       r_gnt;
    logic       r_last_gnt;
    logic       r_is_rd;

    logic        w_act0, w_act1, w_win, w_wr;
    logic [31:0] w_addr, w_wdata;

    assign w_act0  = wr0 | rd0;
    assign w_act1  = wr1 | rd1;
    assign w_win   = pick_winner(w_act0, w_act1, r_last_gnt);
    assign w_wr    = (w_win == REQ_DBG) ? wr1    : wr0;
    assign w_addr  = (w_win == REQ_DBG) ? addr1  : addr0;
    assign w_wdata = (w_win == REQ_DBG) ? wdata1 : wdata0;
    assign busy    = (r_state != ST_IDLE);

`ifdef MEM_ARB_TIMEOUT_EN
    logic w_expired;

    mem_arb_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk      (clk),
        .rst_n    (reset),
        .i_clr    (r_state == ST_IDLE),
        .i_en     (r_state == ST_WAIT),
        .o_expired(w_expired)
    );
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_gnt        <= REQ_CPU;
            r_last_gnt   <= REQ_DBG;
            r_is_rd      <= 1'b0;
            write_enable <= 1'b0;
            read_enable  <= 1'b0;
            address      <= '0;
            write_data   <= '0;
            rdata0       <= '0;
            rdata1       <= '0;
            done0        <= 1'b0;
            done1        <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            err          <= 1'b0;
`endif
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            err   <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_act0 || w_act1) begin
                        address      <= w_addr;
                        write_data   <= w_wdata;
                        write_enable <= w_wr;
                        read_enable  <= ~w_wr;
                        r_is_rd      <= ~w_wr;
                        r_gnt        <= w_win;
                        r_last_gnt   <= w_win;
                        r_state      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // mem_done takes priority over a same-cycle timeout expiry.
                    if (mem_done) begin
                        write_enable <= 1'b0;
                        read_enable  <= 1'b0;
                        if (r_is_rd && r_gnt == REQ_CPU) rdata0 <= read_data;
                        if (r_is_rd && r_gnt == REQ_DBG) rdata1 <= read_data;
                        done0   <= (r_gnt == REQ_CPU);
                        done1   <= (r_gnt == REQ_DBG);
                        r_state <= ST_RESP;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else if (w_expired) begin
                        write_enable <= 1'b0;
                        read_enable  <= 1'b0;
                        if (r_is_rd && r_gnt == REQ_CPU) rdata0 <= ERR_RDATA;
                        if (r_is_rd && r_gnt == REQ_DBG) rdata1 <= ERR_RDATA;
                        done0   <= (r_gnt == REQ_CPU);
                        done1   <= (r_gnt == REQ_DBG);
                        err     <= 1'b1;
                        r_state <= ST_RESP;
                    end
`endif
                end
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
